// File: rtl/uart_rx_buffered.sv
// Configurable UART receiver (5..9 data bits, optional parity, 1 or 2 stop bits)
// with glitch rejection, per-word parity/framing error tags and a first-word
// fall-through RX FIFO with sticky overrun detection.
module uart_rx_buffered #(
    parameter int unsigned BUS_CLK    = 10_000_000,
    parameter int unsigned BAUD       = 9_600,
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_en,
    input  logic                         rx,
    input  logic                         rd_en,
    output logic [DATA_BITS-1:0]         dout,
    output logic                         dout_perr,
    output logic                         dout_ferr,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         recv,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TW    = $clog2(OVERSAMPLE);
    localparam int unsigned EW    = DATA_BITS + 2;

    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_EXP   = (PARITY == 1);

    // Parameter sanity checks, resolved at elaboration
    if (BUS_CLK < BAUD * OVERSAMPLE) begin : g_chk_clk
        $error("BUS_CLK too slow for BAUD * OVERSAMPLE");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_chk_os
        $error("OVERSAMPLE must be even and >= 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_chk_db
        $error("DATA_BITS must be 5..9");
    end
    if ((PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_chk_fmt
        $error("PARITY must be 0..2 and STOP_BITS 1..2");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta, rx_sync;
    logic                 push_req;
    logic [EW-1:0]        push_entry;

    logic [EW-1:0]        mem [DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]        head;
    logic                 do_push, do_pop;
    logic                 overrun_q;

    // Two-flop synchroniser on the asynchronous line, preset to idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Receiver next-state: mid-bit sampling driven by the oversample tick
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push_req   = 1'b0;
        push_entry = '0;
        if (clk_en) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_sync) begin
                        state_d = StStart;
                        tick_d  = '0;
                    end
                end
                StStart: begin
                    if (tick_q == HALF_LAST) begin
                        tick_d = '0;
                        if (rx_sync) begin
                            // Start bit did not hold to mid-bit: treat as a glitch
                            state_d = StIdle;
                        end else begin
                            state_d = StData;
                            bit_d   = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StData: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
                        if (bit_q == DATA_LAST) begin
                            bit_d   = '0;
                            state_d = (PARITY != 0) ? StParity : StStop;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StParity: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        perr_d  = ((^shift_q) ^ rx_sync) != PAR_EXP;
                        bit_d   = '0;
                        state_d = StStop;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                StStop: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d = '0;
                        ferr_d = ferr_q | ~rx_sync;
                        if (bit_q == STOP_LAST) begin
                            // Push without waiting out the stop bit so back-to-back frames work
                            push_req   = 1'b1;
                            push_entry = {perr_q, ferr_q | ~rx_sync, shift_q};
                            state_d    = StIdle;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

    // FIFO status; a pop in the same cycle frees the slot for a push to a full FIFO
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = CNT_W'(wr_ptr_q - rd_ptr_q);
    assign do_pop  = rd_en && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign recv    = do_push;

    // FIFO pointers, flushed by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_entry;
    end

    // Sticky overrun; a drop in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (push_req && full && !do_pop) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;

    // Head outputs are forced to zero while empty so they are stable and reset-clean
    assign head      = mem[rd_ptr_q[AW-1:0]];
    assign dout      = empty ? '0 : head[DATA_BITS-1:0];
    assign dout_ferr = empty ? 1'b0 : head[EW-2];
    assign dout_perr = empty ? 1'b0 : head[EW-1];

endmodule
